mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that sits on the CPU data-memory bus (ce / wrn / addr / wrdata / redata), alongside the data memory, as a second responder.
- CPU stores bytes into an internal TX FIFO; an FSM serialises them 8N1 on txd at a programmable bit period.
- Gives firmware on the core a debug/console output without any change to the CPU pipeline: reads are zero-wait, writes complete at the clock edge.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window (bits [3:0] ignored).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 16'd433, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-low reset (rst=0 resets on the clock edge).
- ce, input, 1, bus select from CPU MEM stage, active high.
- wrn, input, 1, 1 = write, 0 = read; sampled only when ce=1.
- mem_addr, input, 32, byte address.
- mem_data_i, input, 32, write data.
- mem_data_o, output, 32, read data, combinational.
- txd, output, 1, serial line, idle high.
- tx_irq, output, 1, level interrupt.

Behaviour:
- Select: hit = ce & (mem_addr[31:4]==BASE_ADDR[31:4]); offset = mem_addr[3:2]. No hit -> mem_data_o=0, no state change.
- Registers:
  - 0 TXDATA: write pushes mem_data_i[7:0]; read returns 0.
  - 1 STATUS (RO except bit3): bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow (sticky), bits[14:8] count. Writing 1 to bit3 clears it.
  - 2 BAUDDIV: bits[15:0] RW.
  - 3 CTRL: bit0 tx_en, bit2 irq_en, RW; other bits read 0.
- Read mux is combinational in the same cycle ce/addr are presented; no wait states.
- Reset values: txd=1, tx_irq=0, FIFO empty (count 0, pointers 0), overflow=0, BAUDDIV=DEFAULT_DIV, CTRL=0, FSM=IDLE.
  - Reset mid-frame aborts the frame; txd=1 from the reset edge.
- FIFO:
  - Circular buffer with wrap-around pointers and a count of width log2(FIFO_DEPTH)+1.
  - A push when count==FIFO_DEPTH is dropped and sets overflow. Fullness is evaluated on the pre-edge count, so a push arriving on the same edge as a pop while full is still dropped.
  - Push and pop on the same edge when not full: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If tx_en & !empty, pop the head into shift register sr at that edge and go to START.
  - START: txd=0 for BAUDDIV+1 clocks, then DATA with bit index 0.
  - DATA: txd=sr[idx], LSB first, each bit held BAUDDIV+1 clocks; after idx 7, go to STOP.
  - STOP: txd=1 for BAUDDIV+1 clocks, then IDLE.
  - Back-to-back bytes: IDLE lasts exactly 1 clock between frames, so frame pitch = 10*(BAUDDIV+1)+1 clocks.
- Bit timer: 16-bit down-counter loaded with BAUDDIV on each state/bit entry; the bit ends when it reaches 0.
  - A BAUDDIV write mid-frame takes effect at the next bit boundary.
  - BAUDDIV=0 gives 1 clock per bit.
- tx_en cleared mid-frame: the current frame completes; no new pop occurs.
- tx_irq = irq_en & empty & (FSM==IDLE), registered (asserts 1 clock after the condition becomes true).

Optional Feature:
- Macro MMIO_UART_TX_PARITY_EN.
- When defined:
  - CTRL bit1 = parity_en and CTRL bit3 = odd, both RW with reset value 0.
  - When parity_en=1, a PARITY state is inserted between DATA and STOP for BAUDDIV+1 clocks.
  - Parity bit txd = ^sr[7:0] ^ odd.
  - Frame becomes 11 bits.
- When undefined:
  - CTRL bits 1 and 3 read 0 and ignore writes.
  - No PARITY state exists in the RTL.

Test Plan:
- Reset values: hold rst=0 for 3 clocks, then read STATUS -> 0x0000_0002; read BAUDDIV -> 0x0000_01B1; txd=1 throughout.
- Single byte: write BAUDDIV=3, CTRL=1, TXDATA=0x55.
  - Expected txd: start 0 for 4 clocks, then 1,0,1,0,1,0,1,0 each for 4 clocks, then stop 1 for 4 clocks (40 clocks total).
  - Expected STATUS bit2=1 during the frame, 0 after.
- Overflow: with CTRL=0, write 9 bytes 0x01..0x09 (FIFO_DEPTH=8).
  - STATUS -> count=8, full=1, overflow=1.
  - Write STATUS=0x8 -> overflow=0.
  - Set CTRL=1 -> bytes 0x01..0x08 are transmitted in order; 0x09 is never sent.
- Back-to-back and wrap-around: BAUDDIV=0, CTRL=1; push 12 bytes while draining.
  - All 12 serialised in order, with exactly 1 idle clock between frames.
  - Pointers wrap without loss.
- Interrupt: CTRL=0x5, push 1 byte -> tx_irq=0 during the frame; tx_irq=1 exactly 1 clock after STOP→IDLE with the FIFO empty.
- Reset mid-frame and address decode:
  - Drop rst to 0 during DATA bit 3 -> txd=1 and STATUS=0x2 after that edge.
  - A write to BASE_ADDR+0x20 changes nothing, and a read of it returns 0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter that sits on the CPU data bus.
// Register window (16 bytes at BASE_ADDR): 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 CTRL.
// Optional parity bit: define MMIO_UART_TX_PARITY_EN to add CTRL.parity_en/odd
// and a PARITY state between DATA and STOP.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        wrn,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        txd,
   output logic        tx_irq
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

`ifdef MMIO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   // Bus decode
   logic       hit;
   logic [1:0] offset;
   logic       wr_txdata, wr_status, wr_div, wr_ctrl;

   assign hit       = ce & (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign offset    = mem_addr[3:2];
   assign wr_txdata = hit & wrn & (offset == 2'd0);
   assign wr_status = hit & wrn & (offset == 2'd1);
   assign wr_div    = hit & wrn & (offset == 2'd2);
   assign wr_ctrl   = hit & wrn & (offset == 2'd3);

   // Architectural state
   logic [7:0]      fifo_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     div_q, div_d;
   logic            tx_en_q, tx_en_d, irq_en_q, irq_en_d;
`ifdef MMIO_UART_TX_PARITY_EN
   logic            parity_en_q, parity_en_d, odd_q, odd_d;
`endif
   state_e          state_q, state_d;
   logic [15:0]     timer_q, timer_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      sr_q, sr_d;
   logic            irq_q, irq_d;

   logic full, empty, push_ok, pop, bit_done, busy;

   // Fullness uses the pre-edge count, so a push racing a pop while full is dropped.
   assign full     = (count_q == CntW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign push_ok  = wr_txdata & ~full;
   assign pop      = (state_q == StIdle) & tx_en_q & ~empty;
   assign bit_done = (timer_q == 16'd0);
   assign busy     = (state_q != StIdle);

   // Register-file and FIFO bookkeeping next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      div_d    = div_q;
      tx_en_d  = tx_en_q;
      irq_en_d = irq_en_q;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_en_d = parity_en_q;
      odd_d       = odd_q;
`endif
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (wr_txdata & full) begin
         ovf_d = 1'b1;
      end else if (wr_status & mem_data_i[3]) begin
         ovf_d = 1'b0;
      end
      if (wr_div) div_d = mem_data_i[15:0];
      if (wr_ctrl) begin
         tx_en_d  = mem_data_i[0];
         irq_en_d = mem_data_i[2];
`ifdef MMIO_UART_TX_PARITY_EN
         parity_en_d = mem_data_i[1];
         odd_d       = mem_data_i[3];
`endif
      end
   end

   // Transmit FSM: timer reloads from BAUDDIV at every state/bit entry
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      sr_d    = sr_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d = StStart;
               timer_d = div_q;
               sr_d    = fifo_q[rd_ptr_q];
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d = StData;
               idx_d   = 3'd0;
               timer_d = div_q;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         StData: begin
            if (bit_done) begin
               timer_d = div_q;
               if (idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                  state_d = parity_en_q ? StParity : StStop;
`else
                  state_d = StStop;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
`ifdef MMIO_UART_TX_PARITY_EN
         StParity: begin
            if (bit_done) begin
               state_d = StStop;
               timer_d = div_q;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
`endif
         StStop: begin
            if (bit_done) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Level interrupt, registered one clock behind its condition
   always_comb begin
      irq_d = irq_en_q & empty & (state_q == StIdle);
   end

   // Serial line decode from FSM state
   always_comb begin
      txd = 1'b1;
      unique case (state_q)
         StStart: txd = 1'b0;
         StData:  txd = sr_q[idx_q];
`ifdef MMIO_UART_TX_PARITY_EN
         StParity: txd = (^sr_q) ^ odd_q;
`endif
         default: txd = 1'b1;
      endcase
   end

   // Zero-wait combinational read mux
   always_comb begin
      mem_data_o = 32'd0;
      if (hit) begin
         unique case (offset)
            2'd0: mem_data_o = 32'd0;
            2'd1: mem_data_o = {17'd0, 7'(count_q), 4'd0, ovf_q, busy, empty, full};
            2'd2: mem_data_o = {16'd0, div_q};
`ifdef MMIO_UART_TX_PARITY_EN
            2'd3: mem_data_o = {28'd0, odd_q, irq_en_q, parity_en_q, tx_en_q};
`else
            2'd3: mem_data_o = {29'd0, irq_en_q, 1'b0, tx_en_q};
`endif
            default: mem_data_o = 32'd0;
         endcase
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DEFAULT_DIV;
         tx_en_q  <= 1'b0;
         irq_en_q <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
         parity_en_q <= 1'b0;
         odd_q       <= 1'b0;
`endif
         state_q  <= StIdle;
         timer_q  <= 16'd0;
         idx_q    <= 3'd0;
         sr_q     <= 8'd0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         div_q    <= div_d;
         tx_en_q  <= tx_en_d;
         irq_en_q <= irq_en_d;
`ifdef MMIO_UART_TX_PARITY_EN
         parity_en_q <= parity_en_d;
         odd_q       <= odd_d;
`endif
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         sr_q     <= sr_d;
         irq_q    <= irq_d;
      end
   end

   // FIFO storage needs no reset; count and pointers define validity
   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q] <= mem_data_i[7:0];
   end

   assign tx_irq = irq_q;

   logic unused_bits;
   assign unused_bits = ^{mem_data_i[31:16], mem_addr[1:0]};

endmodule
